// File: rtl/insn_line_traverser.sv
// Multi-cycle fetch traverse stage: accepts one I-cache line plus fetch PC, then
// walks it from the PC's halfword offset to the line end, writing parcels into the insn buffer.
module insn_line_traverser #(
   parameter int unsigned LINE_WIDTH     = 128,
   parameter int unsigned WRITE_WIDTH    = 2,
   parameter int unsigned VADDR_WIDTH    = 32,
   parameter int unsigned COUNT_WIDTH    = 4,
   parameter int unsigned INT_CODE_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [VADDR_WIDTH-1:0]            in_pc,
   input  logic [LINE_WIDTH-1:0]             in_line,
   input  logic                              in_tlb_miss,
   input  logic                              in_cache_miss,
   input  logic                              in_tlb_fault,
   input  logic                              int_valid,
   input  logic [INT_CODE_WIDTH-1:0]         int_code,
   input  logic                              flush,
   input  logic [COUNT_WIDTH-1:0]            writable_count,
   output logic [WRITE_WIDTH-1:0]            wr_valid,
   output logic [WRITE_WIDTH*VADDR_WIDTH-1:0] wr_pc,
   output logic [WRITE_WIDTH*16-1:0]         wr_parcel,
   output logic [WRITE_WIDTH-1:0]            wr_fault,
   output logic                              wr_int_valid,
   output logic [INT_CODE_WIDTH-1:0]         wr_int_code,
   output logic                              miss_flush,
   output logic [1:0]                        miss_reason,
   output logic [VADDR_WIDTH-1:0]            miss_pc,
   output logic                              line_done,
   output logic [VADDR_WIDTH-1:0]            next_pc
);

   localparam int unsigned P    = LINE_WIDTH / 16;
   localparam int unsigned CW   = $clog2(P);
   localparam int unsigned OFFW = CW + 1;

   typedef enum logic {S_IDLE, S_TRAVERSE} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CW-1:0]             r_cursor;
   logic [CW-1:0]             w_cursor_nxt;
   logic [LINE_WIDTH-1:0]     r_line;
   logic [VADDR_WIDTH-1:0]    r_base;
   logic                      r_fault;
   logic                      r_int_valid;
   logic [INT_CODE_WIDTH-1:0] r_int_code;
   logic                      w_accept;
   logic                      w_load;
   logic [31:0]               w_rem;
   logic [31:0]               w_n_lim;
   logic [31:0]               w_n;
   logic                      w_done;

   // Reset is gated in so nothing is accepted while the block is held in reset.
   assign in_ready = rst && (r_state == S_IDLE) && !flush;
   assign w_accept = in_valid && in_ready;

   // Parcels this cycle: min(WRITE_WIDTH, parcels left, buffer space), all in 32-bit unsigned.
   assign w_rem   = 32'(P) - 32'(r_cursor);
   assign w_n_lim = (w_rem < 32'(WRITE_WIDTH)) ? w_rem : 32'(WRITE_WIDTH);
   assign w_n     = (32'(writable_count) < w_n_lim) ? 32'(writable_count) : w_n_lim;
   assign w_done  = (32'(r_cursor) + w_n) == 32'(P);

   always_comb begin
      w_state_nxt  = r_state;
      w_cursor_nxt = r_cursor;
      w_load       = 1'b0;
      wr_valid     = '0;
      wr_pc        = '0;
      wr_parcel    = '0;
      wr_fault     = '0;
      wr_int_valid = 1'b0;
      wr_int_code  = '0;
      miss_flush   = 1'b0;
      miss_reason  = 2'd0;
      miss_pc      = '0;
      line_done    = 1'b0;
      next_pc      = '0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (in_tlb_miss) begin
                  miss_flush  = 1'b1;
                  miss_reason = 2'd1;
                  miss_pc     = in_pc;
               end else if (in_cache_miss) begin
                  miss_flush  = 1'b1;
                  miss_reason = 2'd2;
                  miss_pc     = in_pc;
               end else begin
                  w_load       = 1'b1;
                  w_state_nxt  = S_TRAVERSE;
                  w_cursor_nxt = in_pc[CW:1];
               end
            end
         end
         S_TRAVERSE: begin
            if (!flush) begin
               for (int i = 0; i < int'(WRITE_WIDTH); i++) begin
                  if (32'(i) < w_n) begin
                     wr_valid[i] = 1'b1;
                     wr_fault[i] = r_fault;
                     wr_parcel[i*16 +: 16] = r_line[32'(r_cursor + CW'(i)) * 16 +: 16];
                     wr_pc[i*VADDR_WIDTH +: VADDR_WIDTH] =
                        r_base + VADDR_WIDTH'({r_cursor + CW'(i), 1'b0});
                  end
               end
               if (w_n != 32'd0) begin
                  wr_int_valid = r_int_valid;
                  wr_int_code  = r_int_code;
               end
               w_cursor_nxt = CW'(32'(r_cursor) + w_n);
               if (w_done) begin
                  line_done   = 1'b1;
                  next_pc     = r_base + VADDR_WIDTH'(LINE_WIDTH / 8);
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (flush) begin
         w_state_nxt  = S_IDLE;
         w_cursor_nxt = '0;
      end
   end

   // State and cursor register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cursor <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cursor <= w_cursor_nxt;
      end
   end

   // Line payload captured on a clean accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_line      <= '0;
         r_base      <= '0;
         r_fault     <= 1'b0;
         r_int_valid <= 1'b0;
         r_int_code  <= '0;
      end else if (w_load) begin
         r_line      <= in_line;
         r_base      <= {in_pc[VADDR_WIDTH-1:OFFW], OFFW'(0)};
         r_fault     <= in_tlb_fault;
         r_int_valid <= int_valid;
         r_int_code  <= int_code;
      end
   end

endmodule

// File: tb/tb_insn_line_traverser.sv
// Directed bench for insn_line_traverser (P=8, W=2) with hand-computed expectations.
module tb_insn_line_traverser;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_pc;
   logic [127:0] in_line;
   logic         in_tlb_miss;
   logic         in_cache_miss;
   logic         in_tlb_fault;
   logic         int_valid;
   logic [3:0]   int_code;
   logic         flush;
   logic [3:0]   writable_count;
   logic [1:0]   wr_valid;
   logic [63:0]  wr_pc;
   logic [31:0]  wr_parcel;
   logic [1:0]   wr_fault;
   logic         wr_int_valid;
   logic [3:0]   wr_int_code;
   logic         miss_flush;
   logic [1:0]   miss_reason;
   logic [31:0]  miss_pc;
   logic         line_done;
   logic [31:0]  next_pc;

   int n_tests = 0;
   int n_fail  = 0;

   insn_line_traverser dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_line(in_line), .in_tlb_miss(in_tlb_miss), .in_cache_miss(in_cache_miss),
      .in_tlb_fault(in_tlb_fault), .int_valid(int_valid), .int_code(int_code),
      .flush(flush), .writable_count(writable_count), .wr_valid(wr_valid), .wr_pc(wr_pc),
      .wr_parcel(wr_parcel), .wr_fault(wr_fault), .wr_int_valid(wr_int_valid),
      .wr_int_code(wr_int_code), .miss_flush(miss_flush), .miss_reason(miss_reason),
      .miss_pc(miss_pc), .line_done(line_done), .next_pc(next_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_line = '0; in_tlb_miss = 1'b0;
      in_cache_miss = 1'b0; in_tlb_fault = 1'b0; int_valid = 1'b0; int_code = '0;
      flush = 1'b0; writable_count = 4'd8;
      for (int k = 0; k < 8; k++) in_line[k*16 +: 16] = 16'hA000 + 16'(k);

      // Reset state
      tick(); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_line_done", 64'(line_done), 64'd0);
      rst = 1'b1; #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Aligned line at 0x1000
      tick(); in_valid = 1'b1; in_pc = 32'h1000; writable_count = 4'd8; #1;
      chk("al_accept_ready", 64'(in_ready), 64'd1);
      chk("al_accept_miss", 64'(miss_flush), 64'd0);
      for (int c = 0; c < 4; c++) begin
         tick(); in_valid = 1'b0; #1;
         chk("al_wr_valid", 64'(wr_valid), 64'd3);
         chk("al_wr_pc", wr_pc, {32'h1000 + 32'(4*c + 2), 32'h1000 + 32'(4*c)});
         chk("al_parcel", 64'(wr_parcel), 64'({16'hA000 + 16'(2*c + 1), 16'hA000 + 16'(2*c)}));
         chk("al_line_done", 64'(line_done), 64'(c == 3));
         if (c == 3) chk("al_next_pc", 64'(next_pc), 64'h1010);
      end
      tick(); #1;
      chk("al_idle_ready", 64'(in_ready), 64'd1);
      chk("al_idle_wr_valid", 64'(wr_valid), 64'd0);

      // Mid-line start at 0x100A
      in_valid = 1'b1; in_pc = 32'h100A; #1;
      tick(); in_valid = 1'b0; #1;
      chk("mid_c1_valid", 64'(wr_valid), 64'd3);
      chk("mid_c1_pc", wr_pc, {32'h100C, 32'h100A});
      chk("mid_c1_parcel", 64'(wr_parcel), 64'({16'hA006, 16'hA005}));
      chk("mid_c1_done", 64'(line_done), 64'd0);
      tick(); #1;
      chk("mid_c2_valid", 64'(wr_valid), 64'd1);
      chk("mid_c2_pc", wr_pc, {32'h0, 32'h100E});
      chk("mid_c2_parcel", 64'(wr_parcel), 64'({16'h0, 16'hA007}));
      chk("mid_c2_done", 64'(line_done), 64'd1);
      chk("mid_c2_next_pc", 64'(next_pc), 64'h1010);

      // Backpressure: 1, 0, 0, 2
      tick(); in_valid = 1'b1; in_pc = 32'h1000; writable_count = 4'd1;
      tick(); in_valid = 1'b0; #1;
      chk("bp_c1_valid", 64'(wr_valid), 64'd1);
      chk("bp_c1_pc", wr_pc, {32'h0, 32'h1000});
      tick(); writable_count = 4'd0; #1;
      chk("bp_c2_valid", 64'(wr_valid), 64'd0);
      chk("bp_c2_done", 64'(line_done), 64'd0);
      chk("bp_c2_miss", 64'(miss_flush), 64'd0);
      tick(); #1;
      chk("bp_c3_valid", 64'(wr_valid), 64'd0);
      tick(); writable_count = 4'd2; #1;
      chk("bp_c4_valid", 64'(wr_valid), 64'd3);
      chk("bp_c4_pc", wr_pc, {32'h1004, 32'h1002});
      chk("bp_c4_parcel", 64'(wr_parcel), 64'({16'hA002, 16'hA001}));
      tick(); flush = 1'b1; writable_count = 4'd8; #1;
      chk("bp_flush_valid", 64'(wr_valid), 64'd0);
      chk("bp_flush_ready", 64'(in_ready), 64'd0);
      tick(); flush = 1'b0; #1;
      chk("bp_after_ready", 64'(in_ready), 64'd1);

      // Flush in TRAVERSE cycle 2, then a fresh line at 0x3000
      in_valid = 1'b1; in_pc = 32'h1000;
      tick(); in_valid = 1'b0; #1;
      chk("fl_c1_valid", 64'(wr_valid), 64'd3);
      tick(); flush = 1'b1; #1;
      chk("fl_c2_valid", 64'(wr_valid), 64'd0);
      chk("fl_c2_done", 64'(line_done), 64'd0);
      chk("fl_c2_ready", 64'(in_ready), 64'd0);
      tick(); flush = 1'b0; #1;
      chk("fl_idle_ready", 64'(in_ready), 64'd1);
      chk("fl_idle_valid", 64'(wr_valid), 64'd0);
      in_valid = 1'b1; in_pc = 32'h3000;
      tick(); in_valid = 1'b0; #1;
      chk("fl_new_pc", wr_pc, {32'h3002, 32'h3000});
      chk("fl_new_parcel", 64'(wr_parcel), 64'({16'hA001, 16'hA000}));
      tick(); tick(); tick(); #1;
      chk("fl_new_done", 64'(line_done), 64'd1);
      chk("fl_new_next_pc", 64'(next_pc), 64'h3010);

      // Misses
      tick(); in_valid = 1'b1; in_pc = 32'h2004; in_cache_miss = 1'b1; #1;
      chk("cm_flush", 64'(miss_flush), 64'd1);
      chk("cm_reason", 64'(miss_reason), 64'd2);
      chk("cm_pc", 64'(miss_pc), 64'h2004);
      in_tlb_miss = 1'b1; #1;
      chk("tm_reason", 64'(miss_reason), 64'd1);
      flush = 1'b1; #1;
      chk("miss_flush_override", 64'(miss_flush), 64'd0);
      tick(); in_valid = 1'b0; flush = 1'b0; in_tlb_miss = 1'b0; in_cache_miss = 1'b0; #1;
      chk("miss_no_write", 64'(wr_valid), 64'd0);
      chk("miss_stay_idle", 64'(in_ready), 64'd1);
      chk("miss_no_accept", 64'(miss_flush), 64'd0);

      // Fault + interrupt, then async reset mid-line
      in_valid = 1'b1; in_pc = 32'h1000; in_tlb_fault = 1'b1; int_valid = 1'b1; int_code = 4'd7;
      tick(); in_valid = 1'b0; in_tlb_fault = 1'b0; int_valid = 1'b0; int_code = 4'd0; #1;
      chk("fi_fault", 64'(wr_fault), 64'd3);
      chk("fi_int_valid", 64'(wr_int_valid), 64'd1);
      chk("fi_int_code", 64'(wr_int_code), 64'd7);
      tick(); rst = 1'b0; #1;
      chk("ar_valid", 64'(wr_valid), 64'd0);
      chk("ar_ready", 64'(in_ready), 64'd0);
      chk("ar_int", 64'(wr_int_valid), 64'd0);
      chk("ar_fault", 64'(wr_fault), 64'd0);
      tick(); rst = 1'b1; #1;
      chk("ar_rel_ready", 64'(in_ready), 64'd1);
      chk("ar_rel_valid", 64'(wr_valid), 64'd0);
      tick(); #1;
      chk("ar_no_stale", 64'(wr_valid), 64'd0);
      chk("ar_no_done", 64'(line_done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
